dmem_store_buffer: RTL and testbench

- Posted-write buffer between the EX/MEM pipeline register and the data memory (DMEM) in the 5-stage MIPS pipeline.
- Stores from the MEM stage are queued in a small FIFO and written to DMEM in cycles where the MEM stage makes no memory access.
- Loads check the buffer first, youngest entry first; otherwise they read DMEM combinationally in the same cycle.
- A flush FSM drains all pending stores on request, e.g. before halt or a debug memory dump.

---
 rtl/dmem_store_buffer_if.sv | 30 +++
 rtl/dmem_store_buffer.sv | 136 +++++++++++++
 tb/tb_dmem_store_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_store_buffer_if.sv
// CPU-side and DMEM-side signal bundle for the posted-write store buffer.
// The buffer uses the slave view; the pipeline/DMEM harness uses the master view.
interface dmem_store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic              flush_req;
  logic              drained;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_WriteData;
  logic              dm_MemRead;
  logic              dm_MemWrite;
  logic [DATA_W-1:0] dm_ReadData;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata, flush_req, dm_ReadData,
    output cpu_rdata, stall, drained, dm_address, dm_WriteData, dm_MemRead, dm_MemWrite
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata, flush_req, dm_ReadData,
    input  cpu_rdata, stall, drained, dm_address, dm_WriteData, dm_MemRead, dm_MemWrite
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write FIFO between the MEM stage and DMEM: stores queue up and retire
// in cycles with no memory access; loads forward from the youngest matching entry.
//
// state  | meaning
// NORMAL | loads served, stores queued, drain in idle cycles
// FLUSH  | pipeline stalled, one entry drained per cycle until empty
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  dmem_store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_NORMAL = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic              in_flush;
  logic              full;
  logic              is_load;
  logic              stall_c;
  logic              drain;
  logic              enq;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  idx;

  // A simultaneous read+write is decoded as a store; the load half is dropped.
  always_comb begin
    in_flush = (state_q == S_FLUSH);
    full     = (count_q == CNT_W'(DEPTH));
    is_load  = bus.cpu_mem_read && !bus.cpu_mem_write && !in_flush;
    stall_c  = in_flush ? (bus.cpu_mem_read || bus.cpu_mem_write)
                        : (bus.cpu_mem_write && full);
    drain    = in_flush ? (count_q != '0)
                        : ((count_q != '0) && !bus.cpu_mem_read &&
                           (!bus.cpu_mem_write || stall_c));
    enq      = !in_flush && bus.cpu_mem_write && !stall_c;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == bus.cpu_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (enq) begin
      addr_d[tail_q] = bus.cpu_addr;
      data_d[tail_q] = bus.cpu_wdata;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (drain) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_NORMAL;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // FLUSH leaves on the pop that empties the buffer (or at once if already empty).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NORMAL: if (bus.flush_req && (count_q != '0)) state_d = S_FLUSH;
      S_FLUSH:  if (count_d == '0) state_d = S_NORMAL;
      default:  state_d = S_NORMAL;
    endcase
  end

  always_comb begin
    bus.stall        = stall_c;
    bus.drained      = (count_q == '0);
    bus.cpu_rdata    = '0;
    bus.dm_MemRead   = 1'b0;
    bus.dm_MemWrite  = 1'b0;
    bus.dm_address   = '0;
    bus.dm_WriteData = '0;
    if (is_load) begin
      if (hit) begin
        bus.cpu_rdata = hit_data;
      end else begin
        bus.dm_MemRead = 1'b1;
        bus.dm_address = bus.cpu_addr;
        bus.cpu_rdata  = bus.dm_ReadData;
      end
    end else if (drain) begin
      bus.dm_MemWrite  = 1'b1;
      bus.dm_address   = addr_q[head_q];
      bus.dm_WriteData = data_q[head_q];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed plus random bench for dmem_store_buffer against a queue-based
// model of pending stores and a shadow copy of DMEM.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // DMEM: combinational read, write on negedge
  logic [DW-1:0] mem [0:63];
  logic mem_ready = 1'b0;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 0) ? 32'd9 : 32'(i);
      mem_ready <= 1'b1;
    end else if (bus.dm_MemWrite) begin
      mem[bus.dm_address[5:0]] <= bus.dm_WriteData;
    end
  end
  assign bus.dm_ReadData = mem[bus.dm_address[5:0]];

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  ent_t          q[$];
  logic [DW-1:0] ref_mem [0:63];
  bit            flushing = 0;
  logic [AW-1:0] wlog[$];
  int            errors = 0;
  int            checks = 0;

  logic          o_stall, o_mw, o_mr, o_drained;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wd, o_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    o_stall   = bus.stall;
    o_mw      = bus.dm_MemWrite;
    o_mr      = bus.dm_MemRead;
    o_drained = bus.drained;
    o_addr    = bus.dm_address;
    o_wd      = bus.dm_WriteData;
    o_rdata   = bus.cpu_rdata;
  endtask

  // Entered at posedge+1; drives one cycle, checks at posedge+4, advances model.
  task automatic cycle(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic fl);
    logic e_stall, e_mw, e_mr, e_drn;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    bit hit, do_pop, do_push;
    int sz;
    bus.cpu_mem_read  = rd;
    bus.cpu_mem_write = wr;
    bus.cpu_addr      = a;
    bus.cpu_wdata     = d;
    bus.flush_req     = fl;
    sz      = q.size();
    e_stall = flushing ? (rd || wr) : (wr && sz == DEPTH);
    e_drn   = (sz == 0);
    e_mw = 0; e_mr = 0; e_addr = '0; e_wd = '0; e_rd = '0; hit = 0;
    do_pop  = (sz > 0) && (flushing || (!rd && (!wr || e_stall)));
    do_push = !flushing && wr && !e_stall;
    if (!flushing && rd && !wr) begin
      for (int k = sz - 1; k >= 0 && !hit; k--)
        if (q[k].a == a) begin hit = 1; e_rd = q[k].d; end
      if (!hit) begin e_mr = 1; e_addr = a; e_rd = ref_mem[a[5:0]]; end
    end else if (do_pop) begin
      e_mw = 1; e_addr = q[0].a; e_wd = q[0].d;
    end
    #3;
    sample();
    chk("stall", o_stall, e_stall);
    chk("drained", o_drained, e_drn);
    chk("dm_MemWrite", o_mw, e_mw);
    chk("dm_MemRead", o_mr, e_mr);
    chk("dm_address", o_addr, e_addr);
    chk("dm_WriteData", o_wd, e_wd);
    chk("cpu_rdata", o_rdata, e_rd);
    if (o_mw) wlog.push_back(o_addr);
    @(posedge clk);
    if (do_pop) begin
      ref_mem[q[0].a[5:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (do_push) q.push_back('{a, d});
    if (flushing && q.size() == 0) flushing = 0;
    else if (!flushing && fl && sz > 0) flushing = 1;
    #1;
  endtask

  task automatic drain_all();
    for (int n = 0; n < 20 && q.size() > 0; n++) cycle(0, 0, '0, '0, 0);
    cycle(0, 0, '0, '0, 0);
    chk("drain_done", o_drained, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int stall_cycles, n, r;
    logic st_mw;
    logic [AW-1:0] st_addr;
    logic rd, wr, fl;

    for (int i = 0; i < 64; i++) ref_mem[i] = (i == 0) ? 32'd9 : 32'(i);
    bus.cpu_mem_read = 0; bus.cpu_mem_write = 0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.flush_req = 0;

    // reset state
    @(posedge clk); #4;
    sample();
    chk("rst_stall", o_stall, 0);
    chk("rst_drained", o_drained, 1);
    chk("rst_mw", o_mw, 0);
    chk("rst_mr", o_mr, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_wd", o_wd, 0);
    chk("rst_rdata", o_rdata, 0);
    @(posedge clk); #1;
    reset = 1;

    // loads from empty buffer
    cycle(1, 0, 0, '0, 0);
    chk("load0_data", o_rdata, 32'h9);
    chk("load0_mr", o_mr, 1);
    cycle(1, 0, 1, '0, 0);
    chk("load1_data", o_rdata, 32'h1);

    // forward, then drain, then miss
    cycle(0, 1, 2, 32'hDEADBEEF, 0);
    cycle(1, 0, 2, '0, 0);
    chk("fwd_data", o_rdata, 32'hDEADBEEF);
    chk("fwd_mr", o_mr, 0);
    chk("fwd_nodrain", o_mw, 0);
    cycle(0, 0, '0, '0, 0);
    chk("drain_mw", o_mw, 1);
    chk("drain_addr", o_addr, 2);
    cycle(1, 0, 2, '0, 0);
    chk("miss_mr", o_mr, 1);
    chk("miss_data", o_rdata, 32'hDEADBEEF);

    // youngest match wins
    cycle(0, 1, 4, 32'h11, 0);
    cycle(0, 1, 4, 32'h22, 0);
    cycle(0, 1, 5, 32'h33, 0);
    cycle(1, 0, 4, '0, 0);
    chk("youngest", o_rdata, 32'h22);
    drain_all();

    // full buffer: one stall cycle with a drain of the head
    wlog.delete();
    for (int k = 0; k < 4; k++) cycle(0, 1, 32'(8 + k), 32'(100 + k), 0);
    stall_cycles = 0; n = 0; st_mw = 0; st_addr = '0;
    do begin
      cycle(0, 1, 12, 32'd112, 0);
      if (o_stall) begin stall_cycles++; st_mw = o_mw; st_addr = o_addr; end
      n++;
    end while (o_stall && n < 8);
    chk("full_stall_cycles", stall_cycles, 1);
    chk("full_stall_mw", st_mw, 1);
    chk("full_stall_addr", st_addr, 8);
    drain_all();
    chk("order_len", wlog.size(), 5);
    for (int k = 0; k < 5 && k < wlog.size(); k++) chk("order", wlog[k], 8 + k);

    // flush while a load is held
    cycle(0, 1, 30, 32'hA30, 0);
    cycle(0, 1, 31, 32'hA31, 0);
    cycle(0, 1, 32, 32'hA32, 0);
    wlog.delete();
    cycle(1, 0, 0, '0, 1);
    chk("flush_req_stall", o_stall, 0);
    stall_cycles = 0; n = 0;
    do begin
      cycle(1, 0, 0, '0, 0);
      if (o_stall) stall_cycles++;
      n++;
    end while (o_stall && n < 10);
    chk("flush_stall_cycles", stall_cycles, 3);
    chk("flush_pulses", wlog.size(), 3);
    chk("flush_drained", o_drained, 1);
    chk("flush_load_resumes", o_mr, 1);

    // reset mid-run discards queued stores
    cycle(0, 1, 20, 32'hB20, 0);
    cycle(0, 1, 21, 32'hB21, 0);
    bus.cpu_mem_read = 1; bus.cpu_mem_write = 0; bus.cpu_addr = '0;
    #1 reset = 0;
    #1 bus.cpu_mem_read = 0;
    #1 sample();
    chk("midrst_drained", o_drained, 1);
    chk("midrst_stall", o_stall, 0);
    chk("midrst_mw", o_mw, 0);
    #1 reset = 1;
    q.delete();
    flushing = 0;
    @(posedge clk); #1;
    cycle(1, 0, 20, '0, 0);
    chk("midrst_load20", o_rdata, 32'd20);
    cycle(1, 0, 21, '0, 0);
    chk("midrst_load21", o_rdata, 32'd21);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      r  = $urandom_range(0, 99);
      rd = (r < 35);
      wr = (r >= 30 && r < 70);
      fl = ($urandom_range(0, 19) == 0);
      cycle(rd, wr, 32'($urandom_range(0, 7)), $urandom, fl);
    end
    bus.flush_req = 0;
    for (int n2 = 0; n2 < 10 && flushing; n2++) cycle(0, 0, '0, '0, 0);
    drain_all();
    for (int k = 0; k < 16; k++) chk("final_mem", mem[k], ref_mem[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
